// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, mid-bit
// sampling and an optional running sum of received bytes.
// Optional feature: define UART_RX_SUM_EN to build the 32-bit byte
// accumulator behind o_sum; without it o_sum is tied to zero and no
// accumulator register exists.
`timescale 1ns/1ps

module uart_rx #(
  parameter int unsigned cycles_per_bit = 3  // clocks per serial bit, 3..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_serial,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_idle,
  output logic [31:0] o_sum
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Counter compare points: the start bit is sampled half a bit in, every
  // later sample is a whole bit after the previous one, so all samples land
  // near the middle of their bit.
  localparam int unsigned HALF_BIT = cycles_per_bit / 2;
  localparam logic [15:0] HALF_M1  = 16'(HALF_BIT - 1);
  localparam logic [15:0] FULL_M1  = 16'(cycles_per_bit - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        line;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        frame_err_q;

`ifdef UART_RX_SUM_EN
  logic [31:0] sum_q;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others (sync2_q gets old sync1_q).
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_serial;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  // LSB-first shift: each new bit enters at the top and moves down, so the
  // first data bit ends up in bit 0 after eight samples.
  assign shift_d = {line, shift_q[7:1]};

  // Receive FSM with bit-time counter, bit index and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_SUM_EN
      sum_q       <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless re-armed below.
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          // First low cycle on the synchronized line starts a frame.
          if (!line) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A line that is high again by mid start bit was only a glitch.
            state_q   <= line ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            // Back in IDLE right after the stop sample so a start bit that
            // follows with no idle gap is still caught on its first cycle.
            state_q <= ST_IDLE;
            if (line) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
`ifdef UART_RX_SUM_EN
              sum_q   <= sum_q + {24'd0, shift_q};
`endif
            end else begin
              // Bad framing: flag it but keep the last good byte and sum.
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_idle      = (state_q == ST_IDLE);

`ifdef UART_RX_SUM_EN
  assign o_sum = sum_q;
`else
  assign o_sum = '0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx. A frame-level
// model predicts, from the bit timing alone, the clock cycle at which each
// good-byte or framing-error strobe must appear, plus the expected byte and
// running sum; every cycle the DUT outputs are compared against it.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB      = 3;
  localparam int HALF_BIT = CPB / 2;
  // Cycles from driving the start bit to the strobe: 2 synchronizer flops,
  // 1 cycle to see the low line in IDLE, then half a bit plus 9 whole bits
  // to the stop-bit sample.
  localparam int LATENCY  = 3 + HALF_BIT + 9 * CPB;

`ifdef UART_RX_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_serial;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_idle;
  logic [31:0] o_sum;

  always #5 clk = ~clk;

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_serial   (i_serial),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_idle     (o_idle),
    .o_sum      (o_sum)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cycle;
    logic [7:0] data;
    bit         good;
  } ev_t;

  ev_t         evq[$];
  logic [7:0]  exp_data = 8'h00;
  logic [31:0] exp_sum  = 32'h0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Per-cycle comparison against the frame-level model.
  bit         ev_now;
  bit         ev_good;
  logic [7:0] ev_data;
  always @(negedge clk) begin
    if (rst) begin
      exp_data = 8'h00;
      exp_sum  = 32'h0;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ferr",  32'(o_frame_err), 32'd0);
      check("rst_data",  32'(o_data), 32'd0);
      check("rst_sum",   o_sum, 32'd0);
      check("rst_idle",  32'(o_idle), 32'd1);
    end else begin
      ev_now  = 1'b0;
      ev_good = 1'b0;
      ev_data = 8'h00;
      if (evq.size() > 0 && evq[0].cycle == cyc) begin
        ev_now  = 1'b1;
        ev_good = evq[0].good;
        ev_data = evq[0].data;
        void'(evq.pop_front());
      end
      if (ev_now && ev_good) begin
        exp_data = ev_data;
        if (SUM_EN) exp_sum = exp_sum + {24'd0, ev_data};
      end
      check("valid", 32'(o_valid), 32'(ev_now && ev_good));
      check("frame_err", 32'(o_frame_err), 32'(ev_now && !ev_good));
      check("data", 32'(o_data), 32'(exp_data));
      check("sum", o_sum, exp_sum);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one full frame; the caller is positioned 1ns after a rising edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    ev_t e;
    e.cycle = cyc + LATENCY;
    e.data  = b;
    e.good  = stop_ok;
    evq.push_back(e);
    i_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_serial = b[i];
      tick(CPB);
    end
    i_serial = stop_ok;
    tick(CPB);
    i_serial = 1'b1;
    tick(gap);
  endtask

  task automatic do_reset();
    evq.delete();
    rst      = 1'b1;
    i_serial = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic glitch();
    i_serial = 1'b0;
    tick(1);
    i_serial = 1'b1;
    tick(CPB + 2);
  endtask

  logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  logic [7:0] rb;
  int         kind;

  initial begin
    rst      = 1'b1;
    i_serial = 1'b1;
    #3;
    check("init_idle",  32'(o_idle), 32'd1);
    check("init_valid", 32'(o_valid), 32'd0);
    check("init_data",  32'(o_data), 32'd0);
    check("init_sum",   o_sum, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // Single byte 0x55.
    send_frame(8'h55, 1'b1, 5);
    check("x55_data", 32'(o_data), 32'h55);
    check("x55_sum",  o_sum, SUM_EN ? 32'h55 : 32'h0);
    check("x55_idle", 32'(o_idle), 32'd1);

    // "Hello" back-to-back, no idle between frames.
    do_reset();
    foreach (hello[i]) send_frame(hello[i], 1'b1, 0);
    tick(6);
    check("hello_data", 32'(o_data), 32'h6F);
    check("hello_sum",  o_sum, SUM_EN ? 32'h1F4 : 32'h0);

    // One-cycle glitch on an idle line: leaves IDLE briefly, no strobe.
    i_serial = 1'b0;
    tick(1);
    i_serial = 1'b1;
    tick(2);
    check("glitch_start", 32'(o_idle), 32'd0);
    tick(HALF_BIT);
    check("glitch_idle", 32'(o_idle), 32'd1);
    tick(CPB);

    // Framing error on 0xA3, then a clean 0x01.
    send_frame(8'hA3, 1'b0, 2 * CPB);
    check("ferr_data", 32'(o_data), 32'h6F);
    check("ferr_sum",  o_sum, SUM_EN ? 32'h1F4 : 32'h0);
    send_frame(8'h01, 1'b1, 5);
    check("after_ferr_data", 32'(o_data), 32'h01);
    check("after_ferr_sum",  o_sum, SUM_EN ? 32'h1F5 : 32'h0);

    // Reset during data bit 4 of a 0xC9 frame.
    rb       = 8'hC9;
    i_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 5; i++) begin
      i_serial = rb[i];
      tick(CPB);
    end
    tick(1);
    check("pre_rst_busy", 32'(o_idle), 32'd0);
    #2;
    evq.delete();
    rst = 1'b1;
    #1;
    check("async_rst_idle",  32'(o_idle), 32'd1);
    check("async_rst_data",  32'(o_data), 32'd0);
    check("async_rst_sum",   o_sum, 32'd0);
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_ferr",  32'(o_frame_err), 32'd0);
    i_serial = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    send_frame(8'h7E, 1'b1, 5);
    check("post_rst_data", 32'(o_data), 32'h7E);
    check("post_rst_sum",  o_sum, SUM_EN ? 32'h7E : 32'h0);

    // Randomized traffic: good frames with random gaps, bad stops, glitches.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      rb   = 8'($urandom);
      if (kind == 0) glitch();
      else if (kind == 1) send_frame(rb, 1'b0, 2 * CPB);
      else send_frame(rb, 1'b1, int'($urandom_range(0, 4)));
    end
    tick(10);
    check("rand_drained", 32'(evq.size()), 32'd0);
    check("rand_idle",    32'(o_idle), 32'd1);
    check("rand_data",    32'(o_data), 32'(exp_data));
    check("rand_sum",     o_sum, exp_sum);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish (got running, expected done)");
    $fatal(1, "timeout");
  end

endmodule
